// File: rtl/avr_gpio_pcint_pkg.sv
// Shared constants for the avr_gpio_pcint GPIO port: register offsets, block span and bus widths.
package avr_gpio_pcint_pkg;

  localparam int unsigned DATA_W     = 8;
  localparam int unsigned ADDR_W     = 6;
  localparam int unsigned OFS_W      = 3;

  localparam int unsigned OFS_PIN    = 0;
  localparam int unsigned OFS_DDR    = 1;
  localparam int unsigned OFS_PORT   = 2;
  localparam int unsigned OFS_PCMSK  = 3;
  localparam int unsigned OFS_PCIF   = 4;
  localparam int unsigned BLOCK_SPAN = 5;

endpackage

// File: rtl/avr_gpio_pad.sv
// Single GPIO pad: tristate driver plus input tap. ICE40_SYNTHESIS selects an SB_IO primitive;
// AVR_GPIO_PULLUP_EN adds a pull-up on pins configured as input with PORT=1.
module avr_gpio_pad (
  input  logic i_oe,
  input  logic i_out,
  inout  wire  io_pad,
  output logic o_in
);

`ifdef ICE40_SYNTHESIS
  // SB_IO pull-up is a static per-pad attribute, so it cannot follow PORT at run time
  SB_IO #(
    .PIN_TYPE(6'b1010_01),
`ifdef AVR_GPIO_PULLUP_EN
    .PULLUP(1'b1)
`else
    .PULLUP(1'b0)
`endif
  ) u_sb_io (
    .PACKAGE_PIN  (io_pad),
    .OUTPUT_ENABLE(i_oe),
    .D_OUT_0      (i_out),
    .D_IN_0       (o_in)
  );
`else
  assign io_pad = i_oe ? i_out : 1'bz;
`ifdef AVR_GPIO_PULLUP_EN
  // Weak drive so any strong driver on the pad overrides the pull-up
  assign (weak1, weak0) io_pad = (!i_oe && i_out) ? 1'b1 : 1'bz;
`endif
  assign o_in = io_pad;
`endif

endmodule

// File: rtl/avr_gpio_pcint.sv
// AVR I/O-space GPIO port with input synchroniser, PIN-write toggle and pin-change interrupt.
// Optional pad pull-ups are enabled with AVR_GPIO_PULLUP_EN (handled inside avr_gpio_pad).
module avr_gpio_pcint
  import avr_gpio_pcint_pkg::*;
#(
  parameter int unsigned IO_ADDR     = 0,
  parameter int unsigned PORT_WIDTH  = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_W-1:0]     io_addr,
  inout  wire  [DATA_W-1:0]     io_data,
  input  logic                  io_write,
  input  logic                  io_read,
  inout  wire  [PORT_WIDTH-1:0] gpio,
  output logic                  irq
);

  localparam int unsigned ARM_W = 3;
  localparam int unsigned EXT_W = ADDR_W + 1;

  logic [SYNC_STAGES-1:0][PORT_WIDTH-1:0] r_sync;
  logic [PORT_WIDTH-1:0] r_prev;
  logic [PORT_WIDTH-1:0] r_ddr;
  logic [PORT_WIDTH-1:0] r_port;
  logic [PORT_WIDTH-1:0] r_pcmsk;
  logic [PORT_WIDTH-1:0] r_pcif;
  logic [DATA_W-1:0]     r_io_data_out;
  logic [ARM_W-1:0]      r_arm;
  logic                  r_irq;

  logic                  w_hit;
  logic                  w_wr;
  logic                  w_rd;
  logic [OFS_W-1:0]      w_ofs;
  logic [PORT_WIDTH-1:0] w_pad_in;
  logic [PORT_WIDTH-1:0] w_pin;
  logic [PORT_WIDTH-1:0] w_wdata;
  logic [PORT_WIDTH-1:0] w_chg;
  logic [PORT_WIDTH-1:0] w_pcif_clr;
  logic [DATA_W-1:0]     w_rd_data;

  // Address decode; extra bit keeps IO_ADDR+BLOCK_SPAN from wrapping
  assign w_hit = ({1'b0, io_addr} >= EXT_W'(IO_ADDR)) &&
                 ({1'b0, io_addr} <  EXT_W'(IO_ADDR + BLOCK_SPAN));
  assign w_ofs   = OFS_W'(io_addr - ADDR_W'(IO_ADDR));
  assign w_wr    = io_write && w_hit;
  assign w_rd    = io_read && w_hit;
  assign w_wdata = io_data[PORT_WIDTH-1:0];

  assign io_data = w_rd ? r_io_data_out : {DATA_W{1'bz}};
  assign irq     = r_irq;

  for (genvar g = 0; g < PORT_WIDTH; g++) begin : g_pad
    avr_gpio_pad u_pad (
      .i_oe  (r_ddr[g]),
      .i_out (r_port[g]),
      .io_pad(gpio[g]),
      .o_in  (w_pad_in[g])
    );
  end

  assign w_pin      = r_sync[SYNC_STAGES-1];
  assign w_chg      = (r_arm == '0) ? ((w_pin ^ r_prev) & r_pcmsk) : '0;
  assign w_pcif_clr = (w_wr && (w_ofs == OFS_W'(OFS_PCIF))) ? w_wdata : '0;

  always_comb begin
    w_rd_data = '0;
    case (w_ofs)
      OFS_W'(OFS_PIN):   w_rd_data = DATA_W'(w_pin);
      OFS_W'(OFS_DDR):   w_rd_data = DATA_W'(r_ddr);
      OFS_W'(OFS_PORT):  w_rd_data = DATA_W'(r_port);
      OFS_W'(OFS_PCMSK): w_rd_data = DATA_W'(r_pcmsk);
      OFS_W'(OFS_PCIF):  w_rd_data = DATA_W'(r_pcif);
      default:           w_rd_data = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync        <= '0;
      r_prev        <= '0;
      r_ddr         <= '0;
      r_port        <= '0;
      r_pcmsk       <= '0;
      r_pcif        <= '0;
      r_io_data_out <= '0;
      r_irq         <= 1'b0;
      r_arm         <= ARM_W'(SYNC_STAGES + 1);
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], w_pad_in};
      r_prev <= w_pin;
      if (r_arm != '0) r_arm <= r_arm - ARM_W'(1);
      // Set has priority over a write-1-clear on the same edge
      r_pcif <= (r_pcif & ~w_pcif_clr) | w_chg;
      r_irq  <= |r_pcif;
      if (w_rd) r_io_data_out <= w_rd_data;
      if (w_wr) begin
        case (w_ofs)
          OFS_W'(OFS_PIN):   r_port  <= r_port ^ w_wdata;
          OFS_W'(OFS_DDR):   r_ddr   <= w_wdata;
          OFS_W'(OFS_PORT):  r_port  <= w_wdata;
          OFS_W'(OFS_PCMSK): r_pcmsk <= w_wdata;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_avr_gpio_pcint.sv
// Self-checking bench for avr_gpio_pcint: bus reads/writes, toggle, pin-change flags, decode range.
module tb_avr_gpio_pcint;

  localparam int unsigned A  = 8;
  localparam int unsigned SS = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] io_addr = '0;
  logic       io_write = 1'b0;
  logic       io_read = 1'b0;
  logic       irq;
  wire  [7:0] io_data;
  wire  [7:0] gpio;

  logic       tb_io_en = 1'b0;
  logic [7:0] tb_io_val = '0;
  logic [7:0] tb_pin_en = '0;
  logic [7:0] tb_pin_val = '0;

  int total = 0;
  int bad = 0;
  logic [7:0] exp_q[$];
  logic       bit_q[$];

  assign io_data = tb_io_en ? tb_io_val : 8'hzz;
  for (genvar g = 0; g < 8; g++) begin : g_bus
    assign gpio[g] = tb_pin_en[g] ? tb_pin_val[g] : 1'bz;
    pulldown u_pd (io_data[g]);
  end

  avr_gpio_pcint #(.IO_ADDR(A), .PORT_WIDTH(8), .SYNC_STAGES(SS)) dut (
    .clk     (clk),
    .rst     (rst),
    .io_addr (io_addr),
    .io_data (io_data),
    .io_write(io_write),
    .io_read (io_read),
    .gpio    (gpio),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  // Bus tasks are entered on a negedge and return on a negedge
  task automatic bus_write(input int ofs, input logic [7:0] d);
    io_addr = 6'(A + ofs); tb_io_val = d; tb_io_en = 1'b1; io_write = 1'b1;
    @(negedge clk);
    io_write = 1'b0; tb_io_en = 1'b0;
  endtask

  task automatic bus_read(input int ofs, output logic [7:0] d);
    io_addr = 6'(A + ofs); io_read = 1'b1;
    @(negedge clk);
    d = io_data;
    @(negedge clk);
    io_read = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] d, e;
    tb_pin_en = 8'hFF; tb_pin_val = 8'h5A; rst = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (irq !== 1'b0) begin bad++; $display("FAIL reset_irq got=%b exp=0", irq); end
    rst = 1'b0;
    repeat (SS + 1) @(negedge clk);
    exp_q.push_back(8'h5A);
    repeat (4) exp_q.push_back(8'h00);
    for (int o = 0; o < 5; o++) begin
      bus_read(o, d); e = exp_q.pop_front(); total++;
      if (d !== e) begin bad++; $display("FAIL reset_read ofs=%0d got=%h exp=%h", o, d, e); end
    end
    // Second reset: mask opened on the first edge after release, pins already high
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    bus_write(3, 8'hFF);
    repeat (SS + 3) @(negedge clk);
    exp_q.push_back(8'h00);
    bus_read(4, d); e = exp_q.pop_front(); total++;
    if (d !== e) begin bad++; $display("FAIL arm_pcif got=%h exp=%h", d, e); end
    total++;
    if (irq !== 1'b0) begin bad++; $display("FAIL arm_irq got=%b exp=0", irq); end
    bus_write(3, 8'h00);
  endtask

  task automatic test_toggle();
    logic [7:0] d, e;
    tb_pin_en = 8'h00;
    bus_write(1, 8'hFF);
    bus_write(2, 8'hA5);
    bus_write(0, 8'h0F);
    exp_q.push_back(8'hAA);
    bus_read(2, d); e = exp_q.pop_front(); total++;
    if (d !== e) begin bad++; $display("FAIL toggle_port got=%h exp=%h", d, e); end
    total++;
    if (gpio !== 8'hAA) begin bad++; $display("FAIL toggle_gpio got=%h exp=aa", gpio); end
    repeat (SS + 1) @(negedge clk);
    exp_q.push_back(8'hAA);
    bus_read(0, d); e = exp_q.pop_front(); total++;
    if (d !== e) begin bad++; $display("FAIL toggle_pin got=%h exp=%h", d, e); end
    bus_write(1, 8'h0F);
    tb_pin_en = 8'hF0; tb_pin_val = 8'h30;
    repeat (SS + 1) @(negedge clk);
    exp_q.push_back(8'h3A);
    bus_read(0, d); e = exp_q.pop_front(); total++;
    if (d !== e) begin bad++; $display("FAIL ddr_mix_pin got=%h exp=%h", d, e); end
    total++;
    if (gpio[3:0] !== 4'hA) begin bad++; $display("FAIL ddr_mix_gpio got=%h exp=a", gpio[3:0]); end
    bus_write(1, 8'h00);
    tb_pin_en = 8'hFF; tb_pin_val = 8'h00;
    repeat (SS + 2) @(negedge clk);
  endtask

  task automatic test_pcint();
    logic [7:0] d, e;
    logic b, eb;
    bus_write(3, 8'h01);
    exp_q.push_back(8'h00);
    bus_read(4, d); e = exp_q.pop_front(); total++;
    if (d !== e) begin bad++; $display("FAIL pcint_pre got=%h exp=%h", d, e); end
    tb_pin_val = 8'h03;
    bit_q.push_back(1'b0); bit_q.push_back(1'b0); bit_q.push_back(1'b0); bit_q.push_back(1'b1);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      b = irq; eb = bit_q.pop_front(); total++;
      if (b !== eb) begin bad++; $display("FAIL pcint_irq edge=%0d got=%b exp=%b", k, b, eb); end
    end
    exp_q.push_back(8'h01);
    bus_read(4, d); e = exp_q.pop_front(); total++;
    if (d !== e) begin bad++; $display("FAIL pcint_flag got=%h exp=%h", d, e); end
  endtask

  task automatic test_set_wins();
    logic [7:0] d, e;
    logic eb;
    tb_pin_val = 8'h02;
    @(negedge clk);
    @(negedge clk);
    bus_write(4, 8'h01);
    exp_q.push_back(8'h01);
    bus_read(4, d); e = exp_q.pop_front(); total++;
    if (d !== e) begin bad++; $display("FAIL set_wins got=%h exp=%h", d, e); end
    bus_write(4, 8'h01);
    bit_q.push_back(1'b1); bit_q.push_back(1'b0);
    eb = bit_q.pop_front(); total++;
    if (irq !== eb) begin bad++; $display("FAIL clr_irq_hold got=%b exp=%b", irq, eb); end
    @(negedge clk);
    eb = bit_q.pop_front(); total++;
    if (irq !== eb) begin bad++; $display("FAIL clr_irq_drop got=%b exp=%b", irq, eb); end
    exp_q.push_back(8'h00);
    bus_read(4, d); e = exp_q.pop_front(); total++;
    if (d !== e) begin bad++; $display("FAIL clr_pcif got=%h exp=%h", d, e); end
  endtask

  task automatic test_range();
    logic [7:0] d, e;
    int miss_ofs[5] = '{5, 6, 8, 10, -7};
    bus_write(3, 8'hC3);
    exp_q.push_back(8'hC3);
    bus_read(3, d); e = exp_q.pop_front(); total++;
    if (d !== e) begin bad++; $display("FAIL range_pcmsk got=%h exp=%h", d, e); end
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(8'h00);
      bus_read(miss_ofs[i], d); e = exp_q.pop_front(); total++;
      if (d !== e) begin bad++; $display("FAIL miss_read ofs=%0d got=%h exp=released", miss_ofs[i], d); end
    end
    for (int i = 0; i < 5; i++) bus_write(miss_ofs[i], 8'hFF);
    exp_q.push_back(8'h00); exp_q.push_back(8'hAA); exp_q.push_back(8'hC3); exp_q.push_back(8'h00);
    for (int o = 1; o < 5; o++) begin
      bus_read(o, d); e = exp_q.pop_front(); total++;
      if (d !== e) begin bad++; $display("FAIL miss_write ofs=%0d got=%h exp=%h", o, d, e); end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] d, e;
    logic [7:0] vals[3] = '{8'h11, 8'h80, 8'h7E};
    for (int i = 0; i < 3; i++) begin
      bus_write(3, vals[i]); exp_q.push_back(vals[i]);
      bus_read(3, d); e = exp_q.pop_front(); total++;
      if (d !== e) begin bad++; $display("FAIL b2b_pcmsk i=%0d got=%h exp=%h", i, d, e); end
    end
    bus_write(3, 8'h00);
    bus_write(0, 8'hFF); exp_q.push_back(8'h55);
    bus_write(0, 8'hFF); exp_q.push_back(8'hAA);
    bus_write(0, 8'h00); bus_read(2, d);
    e = exp_q.pop_front(); e = exp_q.pop_front(); total++;
    if (d !== e) begin bad++; $display("FAIL b2b_toggle got=%h exp=%h", d, e); end
  endtask

`ifdef AVR_GPIO_PULLUP_EN
  task automatic test_pullup();
    logic [7:0] d;
    bus_write(1, 8'h00);
    bus_write(2, 8'h01);
    tb_pin_en = 8'hFE; tb_pin_val = 8'h00;
    repeat (SS + 1) @(negedge clk);
    bus_read(0, d); total++;
    if (d[0] !== 1'b1) begin bad++; $display("FAIL pullup_pin0 got=%b exp=1", d[0]); end
  endtask
`endif

  initial begin
    @(negedge clk);
    test_reset();
    test_toggle();
    test_pcint();
    test_set_wins();
    test_range();
    test_back_to_back();
`ifdef AVR_GPIO_PULLUP_EN
    test_pullup();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    bad++;
    $display("FAIL watchdog expired got=running exp=finished");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
